pattern_sequencer: RTL and testbench

- 16-step, 4-channel pattern sequencer that replaces hard-coded demo state tables.
- Holds a writable pattern RAM with one entry per (step, channel).
- Advances one step per tempo period and drives the note codes and channel enables consumed by sq_channel (x2), triangle_channel and noise_channel.
- Sits between the control/UI logic and the channel instances, ahead of the mixer.

---
 rtl/seq_pkg.sv | 36 +++
 rtl/seq_tempo_div.sv | 39 +++
 rtl/pattern_sequencer.sv | 149 ++++++++++++++
 tb/tb_pattern_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the pattern sequencer and its helpers.
package seq_pkg;

    localparam int NOTE_REST  = 0;
    localparam int NUM_CH     = 4;

    localparam int CH_SQ1     = 0;
    localparam int CH_SQ2     = 1;
    localparam int CH_TRI     = 2;
    localparam int CH_NOISE   = 3;

    localparam int DEF_NOTE_W = 6;
    localparam int NOTE_LSB   = 0;

    // Entry layout is {hold, gate, note}; offsets depend on the note width.
    function automatic int gate_bit(input int note_w);
        return note_w;
    endfunction

    function automatic int hold_bit(input int note_w);
        return note_w + 1;
    endfunction

    // Pattern entry at the default note width.
    typedef struct packed {
        logic                  hold;
        logic                  gate;
        logic [DEF_NOTE_W-1:0] note;
    } entry_t;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

endpackage

// File: rtl/seq_tempo_div.sv
// Tick counter: counts 0..TICKS_PER_STEP-1 while enabled, flags the terminal
// count, and can be cleared synchronously. Also used for the note clock.
module seq_tempo_div #(
    parameter int TICKS_PER_STEP = 6000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CW = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear dominates, otherwise wrap at the terminal count.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i & (count_q == LAST);

endmodule

// File: rtl/pattern_sequencer.sv
// 16-step, 4-channel pattern sequencer: writable pattern RAM, run/stop FSM,
// and registered note/gate outputs for the sound channels.
module pattern_sequencer #(
    parameter int STEPS          = 16,
    parameter int TICKS_PER_STEP = 6000000,
    parameter int NOTE_W         = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic                       restart,
    input  logic [3:0]                 mute,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_step,
    input  logic [1:0]                 wr_ch,
    input  logic [NOTE_W+1:0]          wr_data,
    output logic [4*NOTE_W-1:0]        note_out,
    output logic [3:0]                 gate_out,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       step_pulse,
    output logic                       beat_led
);

    import seq_pkg::*;

    localparam int SW     = $clog2(STEPS);
    localparam int EW     = NOTE_W + 2;
    localparam int GATE_B = gate_bit(NOTE_W);
    localparam int HOLD_B = hold_bit(NOTE_W);

    state_t                state_q, state_d;
    logic                  load;
    logic [SW-1:0]         load_step;
    logic                  tc;
    logic                  tick_en;

    logic [EW-1:0]         mem_q [STEPS*NUM_CH];
    logic [EW-1:0]         rd_entry [NUM_CH];

    logic [4*NOTE_W-1:0]   note_q, note_d;
    logic [3:0]            gate_q, gate_d;
    logic [SW-1:0]         step_q;
    logic                  pulse_q;
    logic                  led_q;

    assign tick_en = (state_q == ST_RUNNING) & run;

    seq_tempo_div #(
        .TICKS_PER_STEP (TICKS_PER_STEP)
    ) u_tempo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (tick_en),
        .clr_i  (load),
        .tc_o   (tc)
    );

    // FSM next state and step-load decision; restart beats terminal count.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_step = '0;
        case (state_q)
            ST_STOPPED: begin
                if (run) begin
                    state_d = ST_RUNNING;
                    load    = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (!run) begin
                    state_d = ST_STOPPED;
                end else if (restart) begin
                    load = 1'b1;
                end else if (tc) begin
                    load      = 1'b1;
                    load_step = step_q + SW'(1);
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // Entry read for the step being loaded, with same-edge write bypass.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && (wr_step == load_step) && (wr_ch == 2'(i))) begin
                rd_entry[i] = wr_data;
            end else begin
                rd_entry[i] = mem_q[{load_step, 2'(i)}];
            end
        end
    end

    // Output next state: load non-hold entries, mute clears gates at once.
    always_comb begin
        note_d = note_q;
        gate_d = gate_q & ~mute;
        if ((state_q == ST_RUNNING) && !run) begin
            gate_d = '0;
        end else if (load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!rd_entry[i][HOLD_B]) begin
                    note_d[i*NOTE_W +: NOTE_W] = rd_entry[i][NOTE_LSB +: NOTE_W];
                    gate_d[i]                  = rd_entry[i][GATE_B] & ~mute[i];
                end
            end
        end
    end

    // Pattern RAM: one write per cycle, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STEPS*NUM_CH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_en) begin
            mem_q[{wr_step, wr_ch}] <= wr_data;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOPPED;
            note_q  <= '0;
            gate_q  <= '0;
            step_q  <= '0;
            pulse_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            gate_q  <= gate_d;
            pulse_q <= load;
            if (load) begin
                step_q <= load_step;
                led_q  <= ~led_q;
            end
        end
    end

    assign note_out   = note_q;
    assign gate_out   = gate_q;
    assign step_idx   = step_q;
    assign step_pulse = pulse_q;
    assign beat_led   = led_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus random traffic, all
// checked against a step/tempo reference model.
module tb_pattern_sequencer;

    import seq_pkg::*;

    localparam int STEPS = 16;
    localparam int TPS   = 4;
    localparam int NW    = 6;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        restart;
    logic [3:0]  mute;
    logic        wr_en;
    logic [3:0]  wr_step;
    logic [1:0]  wr_ch;
    logic [7:0]  wr_data;
    logic [23:0] note_out;
    logic [3:0]  gate_out;
    logic [3:0]  step_idx;
    logic        step_pulse;
    logic        beat_led;

    pattern_sequencer #(
        .STEPS          (STEPS),
        .TICKS_PER_STEP (TPS),
        .NOTE_W         (NW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .restart    (restart),
        .mute       (mute),
        .wr_en      (wr_en),
        .wr_step    (wr_step),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .note_out   (note_out),
        .gate_out   (gate_out),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .beat_led   (beat_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pattern table plus what is sounding and how long since
    // the last step began.
    bit         m_running;
    int         m_since;
    int         m_step;
    logic [7:0] m_pat [STEPS][4];
    logic [5:0] m_note [4];
    bit         m_gate [4];
    bit         m_pulse;
    bit         m_led;

    task automatic model_reset();
        m_running = 0;
        m_since   = 0;
        m_step    = 0;
        m_pulse   = 0;
        m_led     = 0;
        for (int s = 0; s < STEPS; s++)
            for (int c = 0; c < 4; c++) m_pat[s][c] = '0;
        for (int c = 0; c < 4; c++) begin
            m_note[c] = '0;
            m_gate[c] = 0;
        end
    endtask

    task automatic model_edge();
        bit         ld;
        int         ns;
        logic [7:0] e;
        ld = 0;
        ns = 0;
        if (wr_en) m_pat[wr_step][wr_ch] = wr_data;
        if (!m_running) begin
            if (run) begin
                m_running = 1;
                ld        = 1;
            end
        end else if (!run) begin
            m_running = 0;
            for (int c = 0; c < 4; c++) m_gate[c] = 0;
        end else begin
            m_since++;
            if (restart) begin
                ld = 1;
            end else if (m_since == TPS) begin
                ld = 1;
                ns = (m_step + 1) % STEPS;
            end
        end
        if (ld) begin
            m_since = 0;
            for (int c = 0; c < 4; c++) begin
                e = m_pat[ns][c];
                if (!e[7]) begin
                    m_note[c] = e[5:0];
                    m_gate[c] = e[6] && !mute[c];
                end else begin
                    m_gate[c] = m_gate[c] && !mute[c];
                end
            end
            m_step = ns;
            m_led  = !m_led;
        end else if (m_running) begin
            for (int c = 0; c < 4; c++) m_gate[c] = m_gate[c] && !mute[c];
        end
        m_pulse = ld;
    endtask

    task automatic compare_all();
        logic [23:0] en;
        logic [3:0]  eg;
        for (int c = 0; c < 4; c++) begin
            en[c*NW +: NW] = m_note[c];
            eg[c]          = m_gate[c];
        end
        chk("note_out",   64'(note_out),   64'(en));
        chk("gate_out",   64'(gate_out),   64'(eg));
        chk("step_idx",   64'(step_idx),   64'(m_step));
        chk("step_pulse", 64'(step_pulse), 64'(m_pulse));
        chk("beat_led",   64'(beat_led),   64'(m_led));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_note",  64'(note_out),   64'(0));
        chk("rst_gate",  64'(gate_out),   64'(0));
        chk("rst_step",  64'(step_idx),   64'(0));
        chk("rst_pulse", 64'(step_pulse), 64'(0));
        chk("rst_led",   64'(beat_led),   64'(0));
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_entry(input int s, input int c, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_step = 4'(s);
        wr_ch   = 2'(c);
        wr_data = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic wait_step(input string tag, input int target);
        bit found;
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            cycle();
            if (step_pulse && step_idx == 4'(target)) found = 1;
        end
        chk(tag, 64'(found), 64'(1));
    endtask

    function automatic logic [5:0] ch_note(input int c);
        logic [23:0] v;
        v = note_out;
        return v[c*NW +: NW];
    endfunction

    initial begin
        int npulse;
        run = 0; restart = 0; mute = 0;
        wr_en = 0; wr_step = 0; wr_ch = 0; wr_data = 0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Timing and wrap on channel 0.
        for (int k = 0; k < STEPS; k++) write_entry(k, CH_SQ1, {2'b01, 6'(k + 1)});
        run = 1;
        cycle();
        chk("first_pulse", 64'(step_pulse), 64'(1));
        chk("first_step",  64'(step_idx),   64'(0));
        npulse = 1;
        for (int n = 0; n < 64; n++) begin
            cycle();
            npulse += int'(step_pulse);
        end
        chk("pulse_count", 64'(npulse),         64'(17));
        chk("wrap_step",   64'(step_idx),       64'(0));
        chk("wrap_note",   64'(ch_note(CH_SQ1)), 64'(1));
        chk("led_parity",  64'(beat_led),       64'(1));

        // Hold and mute on channel 1.
        run = 0;
        cycle();
        write_entry(0, CH_SQ2, {2'b01, 6'd41});
        write_entry(1, CH_SQ2, {2'b10, 6'd0});
        write_entry(2, CH_SQ2, {2'b01, 6'd46});
        run = 1;
        cycle();
        chk("hm_note0", 64'(ch_note(CH_SQ2)), 64'(41));
        chk("hm_gate0", 64'(gate_out[1]),     64'(1));
        for (int n = 0; n < 4; n++) cycle();
        chk("hm_step1", 64'(step_idx),        64'(1));
        chk("hm_hold",  64'(ch_note(CH_SQ2)), 64'(41));
        chk("hm_gate1", 64'(gate_out[1]),     64'(1));
        mute = 4'b0010;
        cycle();
        chk("hm_muted", 64'(gate_out[1]),     64'(0));
        chk("hm_note",  64'(ch_note(CH_SQ2)), 64'(41));
        mute = 4'b0000;
        cycle();
        chk("hm_unmute", 64'(gate_out[1]), 64'(0));
        cycle();
        chk("hm_still0", 64'(gate_out[1]), 64'(0));
        cycle();
        chk("hm_step2", 64'(step_idx),        64'(2));
        chk("hm_note2", 64'(ch_note(CH_SQ2)), 64'(46));
        chk("hm_gate2", 64'(gate_out[1]),     64'(1));

        // Stop at step 5, resume from step 0.
        wait_step("wait_s5", 5);
        run = 0;
        cycle();
        chk("stop_gate", 64'(gate_out), 64'(0));
        chk("stop_step", 64'(step_idx), 64'(5));
        cycle();
        run = 1;
        cycle();
        chk("resume_pulse", 64'(step_pulse), 64'(1));
        chk("resume_step",  64'(step_idx),   64'(0));

        // Restart on the terminal count of step 9.
        wait_step("wait_s9", 9);
        for (int n = 0; n < 3; n++) cycle();
        restart = 1;
        cycle();
        restart = 0;
        chk("rs_step",  64'(step_idx),   64'(0));
        chk("rs_pulse", 64'(step_pulse), 64'(1));
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("rs_gap", 64'(step_pulse), 64'(0));
        end
        cycle();
        chk("rs_next_pulse", 64'(step_pulse), 64'(1));
        chk("rs_next_step",  64'(step_idx),   64'(1));

        // Write bypass and write to the sounding step on channel 2.
        wait_step("wait_s2", 2);
        for (int n = 0; n < 3; n++) cycle();
        write_entry(3, CH_TRI, {2'b01, 6'd25});
        chk("byp_step", 64'(step_idx),        64'(3));
        chk("byp_note", 64'(ch_note(CH_TRI)), 64'(25));
        write_entry(3, CH_TRI, {2'b01, 6'd13});
        chk("wsnd_note", 64'(ch_note(CH_TRI)), 64'(25));
        wait_step("wait_s3", 3);
        chk("wsnd_next", 64'(ch_note(CH_TRI)), 64'(13));

        // Reset mid-run, then run still high loads step 0 next cycle.
        cycle();
        do_reset();
        cycle();
        chk("post_rst_pulse", 64'(step_pulse), 64'(1));
        chk("post_rst_step",  64'(step_idx),   64'(0));

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            run     = ($urandom_range(0, 29) != 0);
            restart = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) mute = 4'($urandom);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_step = 4'($urandom);
            wr_ch   = 2'($urandom);
            wr_data = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                do_reset();
            end
            cycle();
        end
        run = 0; restart = 0; wr_en = 0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
